// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M/RV64M multiply/divide unit (shift-add multiply, restoring divide)
module ex_muldiv #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [2:0]            funct3,
    input  logic [XLEN-1:0]       reg1,
    input  logic [XLEN-1:0]       reg2,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic                  flush_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic [XLEN-1:0]       wdata,
    output logic [REG_ADDR_W-1:0] waddr,
    output logic                  we
);
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [2*XLEN-1:0]       acc_q;
    logic [XLEN-1:0]         opb_q;
    logic [2:0]              op_q;
    logic [REG_ADDR_W-1:0]   waddr_cap_q;
    logic                    neg_q;
    logic                    rneg_q;
    logic                    valid_q;
    logic                    we_q;
    logic [XLEN-1:0]         wdata_q;
    logic [REG_ADDR_W-1:0]   waddr_q;

    logic                    is_div_in, sa_in, sb_in, div_zero, div_ovf;
    logic [XLEN-1:0]         mag1, mag2, bypass_res, calc_res;
    logic [XLEN:0]           sum, shifted, diff;
    logic [2*XLEN:0]         mul_full;
    logic [2*XLEN-1:0]       mul_next, div_next, acc_step, prod;
    logic [XLEN-1:0]         quot, rem;

    always_comb begin
        is_div_in  = funct3[2];
        sa_in      = reg1[XLEN-1] & (is_div_in ? ~funct3[0]
                                               : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10));
        sb_in      = reg2[XLEN-1] & (is_div_in ? ~funct3[0] : (funct3[1:0] == 2'b01));
        mag1       = sa_in ? -reg1 : reg1;
        mag2       = sb_in ? -reg2 : reg2;
        div_zero   = is_div_in && (reg2 == '0);
        div_ovf    = is_div_in && !funct3[0] && (reg2 == '1)
                     && (reg1 == {1'b1, {(XLEN-1){1'b0}}});
        // Special divides resolve without iterating; zero divisor wins over overflow.
        bypass_res = div_zero ? (funct3[1] ? reg1 : '1) : (funct3[1] ? '0 : reg1);

        // Multiply: high half accumulates the multiplicand while the multiplier shifts out of the low half.
        sum        = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_full   = {sum, acc_q[XLEN-1:0]};
        mul_next   = mul_full[2*XLEN:1];

        // Divide: high half is the partial remainder, low half shifts dividend out and quotient in.
        shifted    = acc_q[2*XLEN-1:XLEN-1];
        diff       = shifted - {1'b0, opb_q};
        div_next   = {diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0],
                      acc_q[XLEN-2:0], ~diff[XLEN]};

        acc_step   = op_q[2] ? div_next : mul_next;
        prod       = neg_q ? -acc_step : acc_step;
        quot       = acc_step[XLEN-1:0];
        rem        = acc_step[2*XLEN-1:XLEN];
        if (op_q[2])
            calc_res = op_q[1] ? (rneg_q ? -rem : rem) : (neg_q ? -quot : quot);
        else
            calc_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            opb_q       <= '0;
            op_q        <= '0;
            waddr_cap_q <= '0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            valid_q     <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            waddr_q     <= '0;
        end else begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            if (flush_i) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: if (valid_i) begin
                        op_q        <= funct3;
                        waddr_cap_q <= waddr_i;
                        neg_q       <= sa_in ^ sb_in;
                        rneg_q      <= sa_in;
                        cnt_q       <= '0;
                        if (div_zero || div_ovf) begin
                            state_q <= DONE;
                            valid_q <= 1'b1;
                            we_q    <= (waddr_i != '0);
                            wdata_q <= bypass_res;
                            waddr_q <= waddr_i;
                        end else begin
                            state_q <= CALC;
                            acc_q   <= {{XLEN{1'b0}}, is_div_in ? mag1 : mag2};
                            opb_q   <= is_div_in ? mag2 : mag1;
                        end
                    end
                    CALC: begin
                        acc_q <= acc_step;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(XLEN-1)) begin
                            state_q <= DONE;
                            cnt_q   <= '0;
                            valid_q <= 1'b1;
                            we_q    <= (waddr_cap_q != '0);
                            wdata_q <= calc_res;
                            waddr_q <= waddr_cap_q;
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = valid_q;
    assign we      = we_q;
    assign wdata   = wdata_q;
    assign waddr   = waddr_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - scoreboard bench for ex_muldiv at XLEN=32 and XLEN=64
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  fn;
    logic [4:0]  wa_i;
    logic        fl;
    logic        v32, rdy32, vo32, we32;
    logic [31:0] r1_32, r2_32, wd32;
    logic [4:0]  wa32;
    logic        v64, rdy64, vo64, we64;
    logic [63:0] r1_64, r2_64, wd64;
    logic [4:0]  wa64;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  addr;
        logic        we;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    ex_muldiv #(.XLEN(32), .REG_ADDR_W(5)) dut32 (
        .clk(clk), .rst(rst_n), .valid_i(v32), .funct3(fn), .reg1(r1_32), .reg2(r2_32),
        .waddr_i(wa_i), .flush_i(fl), .ready_o(rdy32), .valid_o(vo32), .wdata(wd32),
        .waddr(wa32), .we(we32));

    ex_muldiv #(.XLEN(64), .REG_ADDR_W(5)) dut64 (
        .clk(clk), .rst(rst_n), .valid_i(v64), .funct3(fn), .reg1(r1_64), .reg2(r2_64),
        .waddr_i(wa_i), .flush_i(fl), .ready_o(rdy64), .valid_o(vo64), .wdata(wd64),
        .waddr(wa64), .we(we64));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] model(input int w, input logic [2:0] f,
                                          input logic [63:0] a_in, input logic [63:0] b_in);
        logic [63:0] mask, a, b, r;
        logic signed [127:0] sa, sb, ua, ub, p;
        logic ovf;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        a    = a_in & mask;
        b    = b_in & mask;
        sa   = (w == 64) ? {{64{a[63]}}, a} : {{96{a[31]}}, a[31:0]};
        sb   = (w == 64) ? {{64{b[63]}}, b} : {{96{b[31]}}, b[31:0]};
        ua   = {64'b0, a};
        ub   = {64'b0, b};
        ovf  = (b == mask) && (a == ((w == 64) ? 64'h8000_0000_0000_0000 : 64'h8000_0000));
        case (f)
            3'd0:    p = ua * ub;
            3'd1:    p = sa * sb;
            3'd2:    p = sa * ub;
            3'd3:    p = ua * ub;
            3'd4:    p = (b == 0) ? -1 : (ovf ? ua : sa / sb);
            3'd5:    p = (b == 0) ? -1 : ua / ub;
            3'd6:    p = (b == 0) ? ua : (ovf ? 0 : sa % sb);
            default: p = (b == 0) ? ua : ua % ub;
        endcase
        if (f == 3'd0 || f[2])
            r = p[63:0];
        else
            r = (w == 64) ? p[127:64] : {32'b0, p[63:32]};
        return r & mask;
    endfunction

    task automatic run_op(input int w, input logic [2:0] f, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] addr, input bit poke);
        exp_t e;
        exp_t got_e;
        int   lat;
        bit   got;
        logic [63:0] mask, min;
        mask = (w == 64) ? '1 : 64'hFFFF_FFFF;
        min  = (w == 64) ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
        @(negedge clk);
        fn = f; wa_i = addr;
        if (w == 32) begin v32 = 1'b1; r1_32 = a[31:0]; r2_32 = b[31:0]; end
        else begin v64 = 1'b1; r1_64 = a; r2_64 = b; end
        chk("ready_before_accept", (w == 32) ? rdy32 : rdy64, 1'b1);
        e.data = model(w, f, a, b);
        e.addr = addr;
        e.we   = (addr != 0);
        e.lat  = (f[2] && (((b & mask) == 0) || (!f[0] && (b & mask) == mask && (a & mask) == min)))
                 ? 1 : w + 1;
        sb_q.push_back(e);
        lat = 0;
        got = 1'b0;
        while (!got && lat < w + 8) begin
            @(negedge clk);
            lat++;
            if (poke && lat >= 2 && lat <= 5) begin
                fn = 3'(lat); wa_i = 5'd31;
                if (w == 32) begin v32 = 1'b1; r1_32 = $urandom; r2_32 = $urandom; end
                else begin v64 = 1'b1; r1_64 = {$urandom, $urandom}; end
            end else begin
                v32 = 1'b0; v64 = 1'b0;
            end
            if ((w == 32) ? vo32 : vo64) got = 1'b1;
        end
        v32 = 1'b0; v64 = 1'b0;
        got_e = sb_q.pop_front();
        if (!got) begin
            chk("result_timeout", 64'(got), 64'd1);
        end else begin
            chk("wdata", (w == 32) ? {32'b0, wd32} : wd64, got_e.data);
            chk("waddr", (w == 32) ? wa32 : wa64, got_e.addr);
            chk("we", (w == 32) ? we32 : we64, got_e.we);
            chk("latency", 64'(lat), 64'(got_e.lat));
            @(negedge clk);
            chk("strobe_one_cycle", (w == 32) ? vo32 : vo64, 1'b0);
            chk("ready_after_done", (w == 32) ? rdy32 : rdy64, 1'b1);
            chk("wdata_hold", (w == 32) ? {32'b0, wd32} : wd64, got_e.data);
        end
    endtask

    initial begin
        int strobes;
        rst_n = 1'b0; fl = 1'b0; fn = '0; wa_i = '0;
        v32 = 1'b0; r1_32 = '0; r2_32 = '0;
        v64 = 1'b0; r1_64 = '0; r2_64 = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", rdy32, 1'b1);
        chk("rst_valid", vo32, 1'b0);
        chk("rst_we", we32, 1'b0);
        chk("rst_wdata", wd32, 32'h0);
        chk("rst_waddr", wa32, 5'h0);
        chk("rst_ready64", rdy64, 1'b1);
        @(posedge clk); #2 rst_n = 1'b1;

        run_op(32, 3'd0, 64'd7, 64'hFFFF_FFFE, 5'd5, 1'b0);
        run_op(32, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd6, 1'b0);
        run_op(32, 3'd1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd7, 1'b0);
        run_op(32, 3'd2, 64'hFFFF_FFFF, 64'd2, 5'd3, 1'b0);
        run_op(32, 3'd4, 64'hFFFF_FFF9, 64'd2, 5'd8, 1'b1);
        run_op(32, 3'd6, 64'hFFFF_FFF9, 64'd2, 5'd0, 1'b0);
        run_op(32, 3'd5, 64'd1234, 64'd0, 5'd9, 1'b0);
        run_op(32, 3'd7, 64'd55, 64'd0, 5'd12, 1'b0);
        run_op(32, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 5'd10, 1'b0);
        run_op(32, 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 5'd11, 1'b0);
        for (int i = 0; i < 10; i++)
            run_op(32, 3'($urandom_range(0, 7)), 64'($urandom),
                   (i == 3) ? 64'd0 : 64'($urandom_range(1, 1000)), 5'($urandom), 1'b0);

        // Flush during CALC: the operation must vanish without a strobe.
        strobes = 0;
        @(negedge clk);
        fn = 3'd0; wa_i = 5'd4; v32 = 1'b1; r1_32 = 32'd9; r2_32 = 32'd9;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            v32 = 1'b0;
            if (vo32) strobes++;
        end
        fl = 1'b1;
        @(negedge clk);
        fl = 1'b0;
        chk("flush_valid_low", vo32, 1'b0);
        chk("flush_ready_high", rdy32, 1'b1);
        repeat (40) begin @(negedge clk); if (vo32) strobes++; end
        chk("flush_no_strobe", 64'(strobes), 64'd0);

        // Flush concurrent with a request wins over the accept.
        strobes = 0;
        v32 = 1'b1; fl = 1'b1;
        @(negedge clk);
        v32 = 1'b0; fl = 1'b0;
        chk("flush_beats_accept", rdy32, 1'b1);
        repeat (40) begin @(negedge clk); if (vo32) strobes++; end
        chk("flush_accept_no_strobe", 64'(strobes), 64'd0);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        fn = 3'd4; wa_i = 5'd2; v32 = 1'b1; r1_32 = 32'd100; r2_32 = 32'd7;
        repeat (6) begin @(negedge clk); v32 = 1'b0; end
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", rdy32, 1'b1);
        chk("midrst_valid", vo32, 1'b0);
        chk("midrst_wdata", wd32, 32'h0);
        chk("midrst_waddr", wa32, 5'h0);
        chk("midrst_we", we32, 1'b0);
        @(posedge clk); #2 rst_n = 1'b1;
        run_op(32, 3'd4, 64'd100, 64'd7, 5'd2, 1'b0);

        run_op(64, 3'd0, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFFE, 5'd13, 1'b0);
        run_op(64, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd14, 1'b0);
        run_op(64, 3'd6, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd15, 1'b0);
        run_op(64, 3'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd16, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The block SHALL expose parameter XLEN, default 32, giving the operand and result width in bits; legal values are 32 and 64.
REQ-002 The block SHALL expose parameter REG_ADDR_W, default 5, giving the destination register address width.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  is the reset; it SHALL be asynchronous and active-low.
REQ-005 Port valid_i  input  1  SHALL indicate an RV32M/RV64M-class operation request.
REQ-006 Port funct3  input  3  SHALL select the operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 Port reg1  input  XLEN  SHALL carry operand rs1.
REQ-008 Port reg2  input  XLEN  SHALL carry operand rs2.
REQ-009 Port waddr_i  input  REG_ADDR_W  SHALL carry the destination register address.
REQ-010 Port flush_i  input  1  SHALL request abort of any operation in flight.
REQ-011 Port ready_o  output  1  SHALL be high only in IDLE.
REQ-012 Port valid_o  output  1  SHALL mark a one-cycle result strobe.
REQ-013 Port wdata  output  XLEN  SHALL carry the result.
REQ-014 Port waddr  output  REG_ADDR_W  SHALL carry the captured destination address.
REQ-015 Port we  output  1  SHALL equal valid_o and be suppressed when the captured address is 0.

Function
REQ-016 The block SHALL implement FSM states IDLE, CALC and DONE.
REQ-017 A request SHALL be accepted on a rising edge where valid_i and ready_o are both high; funct3, waddr_i and both operands SHALL be captured at that edge.
REQ-018 valid_i SHALL be ignored outside IDLE; captured values SHALL NOT change until return to IDLE.
REQ-019 On acceptance of a normal operation, IDLE SHALL go to CALC with a cycle counter cleared to 0.
REQ-020 CALC SHALL perform one shift-add multiply step or one restoring-divide step per cycle, for exactly XLEN cycles, then go to DONE.
REQ-021 DONE SHALL last one cycle with valid_o high, then go to IDLE; total latency SHALL be XLEN+1 cycles from the accept edge to valid_o high.
REQ-022 Signed operands SHALL be converted to magnitudes before iteration; the sign SHALL be corrected in the DONE result.
REQ-023 MUL SHALL return the low XLEN bits of the 2*XLEN-bit product; MULH, MULHSU and MULHU SHALL return the high XLEN bits, with signedness signed/signed, signed/unsigned and unsigned/unsigned respectively.
REQ-024 Divide by zero SHALL bypass CALC and go IDLE to DONE, giving valid_o one cycle after the accept edge; DIV/DIVU SHALL return all ones and REM/REMU SHALL return reg1.
REQ-025 DIV/REM overflow (reg1 = most-negative value, reg2 = all ones) SHALL also bypass CALC with 1-cycle latency; DIV SHALL return reg1 and REM SHALL return 0.
REQ-026 flush_i high at a rising edge SHALL force IDLE at that edge from any state; valid_o SHALL stay low, and flush SHALL take priority over a concurrent accept.
REQ-027 wdata and waddr SHALL hold their last values outside DONE.
REQ-028 Remainder sign SHALL follow the dividend and the quotient SHALL truncate toward zero.

Reset
REQ-029 While rst is low, the state SHALL be IDLE, the counter 0, valid_o and we 0, wdata 0, waddr 0, and ready_o 1.
REQ-030 Reset asserted mid-CALC SHALL abort the operation immediately with no result strobe; the first accept SHALL be possible at the first rising edge after rst deasserts.

Verification
REQ-031 Scenario: MUL with reg1=7 and reg2=0xFFFFFFFE (XLEN=32) -> valid_o at edge +33, wdata=0xFFFFFFF2, we=1.
REQ-032 Scenario: MULHU with 0xFFFFFFFF x 0xFFFFFFFF -> wdata=0xFFFFFFFE; MULH with the same operands -> wdata=0x00000000.
REQ-033 Scenario: DIV with -7/2 -> wdata=0xFFFFFFFD; REM with -7/2 -> 0xFFFFFFFF; each at latency 33.
REQ-034 Scenario: DIVU with x/0 -> wdata=0xFFFFFFFF, latency 1; DIV with 0x80000000/0xFFFFFFFF -> 0x80000000, latency 1.
REQ-035 Scenario: flush_i pulsed at CALC cycle 10 -> no valid_o, ready_o=1 next cycle; a new request issued while busy -> ignored.
REQ-036 Scenario: rst driven low mid-CALC, then released, then a new request issued -> the new result is correct with full latency and no stale strobe; XLEN=64 regression -> latency 65.
